// File: rtl/temporizador_regressivo_if.sv
// Bus bundle for the loadable down-counting round timer.
// The control side (master) drives load/start/pause/tick and reads back the
// count and status; the timer itself sits on the slave modport.
interface temporizador_regressivo_if #(
    parameter int WIDTH = 16
);
    // Control towards the timer
    logic             ld;        // active-low synchronous load
    logic [WIDTH-1:0] D;         // load value (count and preset)
    logic             iniciar;   // start / restart request
    logic             pausar;    // hold the count while high
    logic             tick;      // one-clock decrement enable

    // Status from the timer
    logic [WIDTH-1:0] Q;         // current count
    logic             timeout;   // high while expired
    logic             fim;       // one-cycle pulse on expiry
    logic             contando;  // high while counting
    logic [1:0]       estado;    // 00 idle, 01 counting, 10 paused, 11 expired

    modport master (
        output ld,
        output D,
        output iniciar,
        output pausar,
        output tick,
        input  Q,
        input  timeout,
        input  fim,
        input  contando,
        input  estado
    );

    modport slave (
        input  ld,
        input  D,
        input  iniciar,
        input  pausar,
        input  tick,
        output Q,
        output timeout,
        output fim,
        output contando,
        output estado
    );
endinterface

// File: rtl/temporizador_regressivo.sv
// Loadable down-counting timer used as the per-round time limit.
// A preset is loaded with ld (active low), counting starts on iniciar and the
// count drops by one per qualifying tick. Expiry is reported with a one-cycle
// fim pulse and a held timeout level; iniciar after expiry reloads the stored
// preset and counts again.
module temporizador_regressivo #(
    parameter int WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    clr,
    temporizador_regressivo_if.slave bus
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        CONTANDO = 2'b01,
        PAUSADO  = 2'b10,
        ESGOTADO = 2'b11
    } estado_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    estado_t          estado_q, estado_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic             fim_q, fim_d;
    logic             timeout_q, timeout_d;

    // Decoded count conditions, shared by the next-state logic.
    logic q_is_zero;
    logic q_is_one;
    logic preset_is_zero;

    assign q_is_zero      = (q_q == ZERO);
    assign q_is_one       = (q_q == ONE);
    assign preset_is_zero = (preset_q == ZERO);

    // Next state, next count and expiry pulse; a load overrides everything.
    always_comb begin
        estado_d = estado_q;
        q_d      = q_q;
        preset_d = preset_q;
        fim_d    = 1'b0;

        if (!bus.ld) begin
            q_d      = bus.D;
            preset_d = bus.D;
            estado_d = OCIOSO;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    // Starting with nothing to count expires immediately.
                    if (bus.iniciar) begin
                        if (q_is_zero) begin
                            estado_d = ESGOTADO;
                            fim_d    = 1'b1;
                        end else begin
                            estado_d = CONTANDO;
                        end
                    end
                end

                CONTANDO: begin
                    // Pause takes precedence over a coincident tick.
                    if (bus.pausar) begin
                        estado_d = PAUSADO;
                    end else if (bus.tick) begin
                        if (q_is_one) begin
                            q_d      = ZERO;
                            estado_d = ESGOTADO;
                            fim_d    = 1'b1;
                        end else if (!q_is_zero) begin
                            q_d = q_q - ONE;
                        end
                    end
                end

                PAUSADO: begin
                    if (!bus.pausar) begin
                        estado_d = CONTANDO;
                    end
                end

                ESGOTADO: begin
                    // Restart from the stored preset; an empty preset just
                    // re-announces expiry.
                    if (bus.iniciar) begin
                        if (preset_is_zero) begin
                            fim_d = 1'b1;
                        end else begin
                            q_d      = preset_q;
                            estado_d = CONTANDO;
                        end
                    end
                end

                default: begin
                    estado_d = OCIOSO;
                end
            endcase
        end

        // timeout is registered so it lines up with the state it reports.
        timeout_d = (estado_d == ESGOTADO);
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            estado_q  <= OCIOSO;
            q_q       <= ZERO;
            preset_q  <= ZERO;
            fim_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            q_q       <= q_d;
            preset_q  <= preset_d;
            fim_q     <= fim_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs come straight from registers or from decoding the state register.
    assign bus.Q        = q_q;
    assign bus.timeout  = timeout_q;
    assign bus.fim      = fim_q;
    assign bus.estado   = estado_q;
    assign bus.contando = (estado_q == CONTANDO);

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Directed bench for the down-counting round timer.
module tb_temporizador_regressivo;

    localparam int W = 16;

    logic clock;
    logic clr;
    int   checks;
    int   failures;

    temporizador_regressivo_if #(.WIDTH(W)) bus ();

    temporizador_regressivo #(.WIDTH(W)) dut (
        .clock (clock),
        .clr   (clr),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle before sampling or driving.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ld      = 1'b1;
        bus.D       = '0;
        bus.iniciar = 1'b0;
        bus.pausar  = 1'b0;
        bus.tick    = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] value);
        bus.ld = 1'b0;
        bus.D  = value;
        cyc();
        bus.ld = 1'b1;
    endtask

    task automatic do_start();
        bus.iniciar = 1'b1;
        cyc();
        bus.iniciar = 1'b0;
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        clr = 1'b0;
        cyc();
        cyc();
        checks++; if (bus.Q !== 16'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", bus.Q); end
        checks++; if (bus.estado !== 2'b00) begin failures++; $display("FAIL reset_estado got=%b exp=00", bus.estado); end
        checks++; if ({bus.fim, bus.timeout, bus.contando} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bus.fim, bus.timeout, bus.contando}); end
        clr = 1'b1;
        cyc();
        $display("test_reset done");
    endtask

    task automatic test_basic_countdown();
        logic [W-1:0] exp_q;
        do_load(16'd3);
        checks++; if (bus.Q !== 16'd3 || bus.estado !== 2'b00) begin failures++; $display("FAIL basic_load got q=%0d estado=%b exp q=3 estado=00", bus.Q, bus.estado); end
        do_start();
        checks++; if (bus.estado !== 2'b01 || bus.contando !== 1'b1 || bus.Q !== 16'd3) begin failures++; $display("FAIL basic_start got estado=%b contando=%b q=%0d exp 01/1/3", bus.estado, bus.contando, bus.Q); end
        // No tick: count must not move.
        cyc();
        checks++; if (bus.Q !== 16'd3) begin failures++; $display("FAIL basic_notick got=%0d exp=3", bus.Q); end
        exp_q = 16'd3;
        for (int i = 0; i < 3; i++) begin
            cyc(); cyc(); cyc();
            do_tick();
            exp_q = exp_q - 16'd1;
            checks++; if (bus.Q !== exp_q) begin failures++; $display("FAIL basic_step%0d got=%0d exp=%0d", i, bus.Q, exp_q); end
            if (exp_q != 16'd0) begin
                checks++; if (bus.fim !== 1'b0 || bus.timeout !== 1'b0) begin failures++; $display("FAIL basic_early_fim step%0d got fim=%b timeout=%b exp 0/0", i, bus.fim, bus.timeout); end
            end
        end
        checks++; if (bus.fim !== 1'b1 || bus.timeout !== 1'b1 || bus.estado !== 2'b11) begin failures++; $display("FAIL basic_expiry got fim=%b timeout=%b estado=%b exp 1/1/11", bus.fim, bus.timeout, bus.estado); end
        do_tick();
        checks++; if (bus.fim !== 1'b0 || bus.timeout !== 1'b1 || bus.estado !== 2'b11 || bus.Q !== 16'd0) begin failures++; $display("FAIL basic_after got fim=%b timeout=%b estado=%b q=%0d exp 0/1/11/0", bus.fim, bus.timeout, bus.estado, bus.Q); end
        $display("test_basic_countdown done");
    endtask

    task automatic test_pause();
        do_load(16'd5);
        checks++; if (bus.timeout !== 1'b0 || bus.estado !== 2'b00) begin failures++; $display("FAIL pause_load got timeout=%b estado=%b exp 0/00", bus.timeout, bus.estado); end
        do_start();
        do_tick();
        do_tick();
        checks++; if (bus.Q !== 16'd3) begin failures++; $display("FAIL pause_pre got=%0d exp=3", bus.Q); end
        bus.pausar = 1'b1;
        cyc();
        bus.tick = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        bus.tick = 1'b0;
        checks++; if (bus.Q !== 16'd3 || bus.estado !== 2'b10 || bus.contando !== 1'b0) begin failures++; $display("FAIL pause_hold got q=%0d estado=%b contando=%b exp 3/10/0", bus.Q, bus.estado, bus.contando); end
        bus.pausar = 1'b0;
        cyc();
        checks++; if (bus.estado !== 2'b01 || bus.Q !== 16'd3) begin failures++; $display("FAIL pause_resume got estado=%b q=%0d exp 01/3", bus.estado, bus.Q); end
        do_tick();
        checks++; if (bus.Q !== 16'd2) begin failures++; $display("FAIL pause_next got=%0d exp=2", bus.Q); end
        $display("test_pause done");
    endtask

    task automatic test_tick_vs_pause();
        do_load(16'd4);
        do_start();
        bus.pausar = 1'b1;
        bus.tick   = 1'b1;
        cyc();
        bus.tick   = 1'b0;
        checks++; if (bus.Q !== 16'd4 || bus.estado !== 2'b10) begin failures++; $display("FAIL tick_vs_pause got q=%0d estado=%b exp 4/10", bus.Q, bus.estado); end
        bus.pausar = 1'b0;
        cyc();
        $display("test_tick_vs_pause done");
    endtask

    task automatic test_load_mid();
        // Continues from CONTANDO with Q=4.
        do_tick();
        do_tick();
        checks++; if (bus.Q !== 16'd2 || bus.estado !== 2'b01) begin failures++; $display("FAIL load_mid_pre got q=%0d estado=%b exp 2/01", bus.Q, bus.estado); end
        bus.ld      = 1'b0;
        bus.D       = 16'd9;
        bus.iniciar = 1'b1;
        bus.tick    = 1'b1;
        cyc();
        idle_inputs();
        checks++; if (bus.Q !== 16'd9 || bus.estado !== 2'b00 || bus.fim !== 1'b0) begin failures++; $display("FAIL load_mid got q=%0d estado=%b fim=%b exp 9/00/0", bus.Q, bus.estado, bus.fim); end
        do_start();
        do_tick();
        checks++; if (bus.Q !== 16'd8 || bus.estado !== 2'b01) begin failures++; $display("FAIL load_mid_count got q=%0d estado=%b exp 8/01", bus.Q, bus.estado); end
        $display("test_load_mid done");
    endtask

    task automatic test_restart_and_zero();
        do_load(16'd3);
        do_start();
        do_tick();
        do_tick();
        do_tick();
        checks++; if (bus.estado !== 2'b11 || bus.Q !== 16'd0) begin failures++; $display("FAIL restart_expired got estado=%b q=%0d exp 11/0", bus.estado, bus.Q); end
        do_start();
        checks++; if (bus.Q !== 16'd3 || bus.estado !== 2'b01 || bus.timeout !== 1'b0) begin failures++; $display("FAIL restart got q=%0d estado=%b timeout=%b exp 3/01/0", bus.Q, bus.estado, bus.timeout); end
        do_load(16'd0);
        do_start();
        checks++; if (bus.estado !== 2'b11 || bus.fim !== 1'b1 || bus.Q !== 16'd0) begin failures++; $display("FAIL zero_start got estado=%b fim=%b q=%0d exp 11/1/0", bus.estado, bus.fim, bus.Q); end
        cyc();
        checks++; if (bus.fim !== 1'b0 || bus.timeout !== 1'b1) begin failures++; $display("FAIL zero_single got fim=%b timeout=%b exp 0/1", bus.fim, bus.timeout); end
        // Held iniciar with an empty preset re-pulses fim every cycle.
        bus.iniciar = 1'b1;
        cyc();
        checks++; if (bus.fim !== 1'b1) begin failures++; $display("FAIL zero_repulse1 got=%b exp=1", bus.fim); end
        cyc();
        checks++; if (bus.fim !== 1'b1 || bus.estado !== 2'b11) begin failures++; $display("FAIL zero_repulse2 got fim=%b estado=%b exp 1/11", bus.fim, bus.estado); end
        bus.iniciar = 1'b0;
        cyc();
        $display("test_restart_and_zero done");
    endtask

    task automatic test_async_reset();
        do_load(16'd7);
        do_start();
        checks++; if (bus.Q !== 16'd7 || bus.estado !== 2'b01) begin failures++; $display("FAIL areset_pre got q=%0d estado=%b exp 7/01", bus.Q, bus.estado); end
        #2;
        clr = 1'b0;
        #1;
        checks++; if (bus.Q !== 16'd0 || bus.estado !== 2'b00 || bus.timeout !== 1'b0 || bus.contando !== 1'b0) begin failures++; $display("FAIL areset_mid got q=%0d estado=%b timeout=%b contando=%b exp 0/00/0/0", bus.Q, bus.estado, bus.timeout, bus.contando); end
        cyc();
        clr = 1'b1;
        cyc();
        do_start();
        checks++; if (bus.estado !== 2'b11 || bus.Q !== 16'd0 || bus.fim !== 1'b1) begin failures++; $display("FAIL areset_start got estado=%b q=%0d fim=%b exp 11/0/1", bus.estado, bus.Q, bus.fim); end
        // Clear from ESGOTADO with fim high must drop timeout and fim at once.
        #2;
        clr = 1'b0;
        #1;
        checks++; if (bus.timeout !== 1'b0 || bus.fim !== 1'b0 || bus.estado !== 2'b00) begin failures++; $display("FAIL areset_expired got timeout=%b fim=%b estado=%b exp 0/0/00", bus.timeout, bus.fim, bus.estado); end
        cyc();
        clr = 1'b1;
        cyc();
        $display("test_async_reset done");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clr      = 1'b0;
        idle_inputs();
        test_reset();
        test_basic_countdown();
        test_pause();
        test_tick_vs_pause();
        test_load_mid();
        test_restart_and_zero();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
